// File: rtl/gray_seq_ctrl.sv
// Gray-code range sequencer: walks lo..hi (or hi..lo) on a valid/ready stream.
// Optional wrap-around looping is enabled by defining GRAY_SEQ_LOOP_EN (adds loop_i).

module bin2gray #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);
  assign gray_o = bin_i ^ (bin_i >> 1);
endmodule

module gray_seq_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             dir_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] hi_i,
`ifdef GRAY_SEQ_LOOP_EN
  input  logic             loop_i,
`endif
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] bin_o,
  output logic [WIDTH-1:0] gray_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic             loop_q, loop_d;
  logic             is_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
      loop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
      loop_q  <= loop_d;
    end
  end

  // Terminal compare stops the walk before the counter could wrap.
  assign is_last = dir_q ? (bin_q == lo_q) : (bin_q == hi_q);

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dir_d   = dir_q;
    err_d   = 1'b0;
    loop_d  = loop_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (lo_i <= hi_i) begin
            lo_d    = lo_i;
            hi_d    = hi_i;
            dir_d   = dir_i;
`ifdef GRAY_SEQ_LOOP_EN
            loop_d  = loop_i;
`else
            loop_d  = 1'b0;
`endif
            bin_d   = dir_i ? hi_i : lo_i;
            state_d = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (ready_i) begin
          if (is_last) begin
            if (loop_q) begin
              bin_d = dir_q ? hi_q : lo_q;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            bin_d = dir_q ? (bin_q - WIDTH'(1)) : (bin_q + WIDTH'(1));
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
    .bin_i  (bin_q),
    .gray_o (gray_o)
  );

  assign bin_o   = bin_q;
  assign valid_o = (state_q == ST_RUN);
  assign busy_o  = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done_o  = (state_q == ST_DONE);
  assign err_o   = err_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Randomized + directed bench for gray_seq_ctrl against a queue-based reference model.
// Exercises the loop feature only when GRAY_SEQ_LOOP_EN is defined.

module tb_gray_seq_ctrl;
  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, stop = 1'b0, dir = 1'b0, ready = 1'b0, loop = 1'b0;
  logic [W-1:0] lo = '0, hi = '0;
  logic         valid_o, busy_o, done_o, err_o;
  logic [W-1:0] bin_o, gray_o;

  int n_total = 0;
  int n_bad   = 0;

  // reference model: queue of values still to be delivered in the current run
  int   q[$];
  bit   m_active, m_done, m_err, m_loop, m_dir;
  int   m_bin, m_lo, m_hi;
  bit   have_prev;
  logic [W-1:0] prev_gray;

  int gray_tbl[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  always #5 clk = ~clk;

  gray_seq_ctrl #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .stop_i  (stop),
    .dir_i   (dir),
    .lo_i    (lo),
    .hi_i    (hi),
`ifdef GRAY_SEQ_LOOP_EN
    .loop_i  (loop),
`endif
    .ready_i (ready),
    .valid_o (valid_o),
    .bin_o   (bin_o),
    .gray_o  (gray_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int to_gray(input int b);
    int g = 0;
    for (int i = W - 1; i >= 0; i--) begin
      int hib = (i == W - 1) ? 0 : ((b >> (i + 1)) & 1);
      g = g | ((((b >> i) & 1) ^ hib) << i);
    end
    return g;
  endfunction

  task automatic fill();
    q.delete();
    if (!m_dir) for (int v = m_lo; v <= m_hi; v++) q.push_back(v);
    else        for (int v = m_hi; v >= m_lo; v--) q.push_back(v);
  endtask

  task automatic model_reset();
    q.delete();
    m_active = 0; m_done = 0; m_err = 0; m_loop = 0; m_dir = 0;
    m_bin = 0; m_lo = 0; m_hi = 0; have_prev = 0;
  endtask

  task automatic check_outputs();
    check("valid", valid_o, m_active);
    check("bin",   bin_o,   m_bin);
    check("gray",  gray_o,  to_gray(m_bin));
    check("busy",  busy_o,  m_active | m_done);
    check("done",  done_o,  m_done);
    check("err",   err_o,   m_err);
  endtask

  // one clock: advance the model with the inputs present at the edge, then check
  task automatic step();
    bit nd = 0, ne = 0;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_active && !stop && ready) begin
        if (have_prev) check("onebit", $countones(prev_gray ^ gray_o), 1);
        prev_gray = gray_o;
        have_prev = 1;
      end
      if (m_done) begin
        // DONE always returns to idle
      end else if (!m_active) begin
        if (start) begin
          if (lo <= hi) begin
            m_lo = lo; m_hi = hi; m_dir = dir; m_loop = loop;
            fill();
            m_bin = q[0];
            m_active = 1;
            have_prev = 0;
          end else ne = 1;
        end
      end else if (stop) begin
        m_active = 0;
        have_prev = 0;
      end else if (ready) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          have_prev = 0;
          if (m_loop) begin
            fill();
            m_bin = q[0];
          end else begin
            m_active = 0;
            nd = 1;
          end
        end else m_bin = q[0];
      end
      m_done = nd;
      m_err  = ne;
    end
    #1;
    check_outputs();
  endtask

  task automatic run_until_idle(input int budget, input bit toggle_ready);
    int n = 0;
    while ((m_active || m_done) && n < budget) begin
      if (toggle_ready) ready = ~ready;
      step();
      n++;
    end
    if (m_active || m_done) check("timeout", 1, 0);
  endtask

  task automatic start_run(input int l, input int h, input bit d);
    lo = l[W-1:0]; hi = h[W-1:0]; dir = d; start = 1;
    step();
    start = 0;
  endtask

  initial begin
    int guard;
    model_reset();
    #1;
    check_outputs();
    step(); step();
    rst_n = 1;

    // full range, up, ready held high: compare against the known Gray table
    ready = 1;
    start_run(0, 15, 0);
    for (int i = 0; i < 16; i++) begin
      check("gray_tbl", gray_o, gray_tbl[i]);
      step();
    end
    check("done_pulse", done_o, 1);
    step();

    // 3..6 down with ready toggling
    ready = 0;
    start_run(3, 6, 1);
    run_until_idle(40, 1);
    step();

    // rejected start, then a valid one
    start_run(9, 2, 0);
    check("err_pulse", err_o, 1);
    step();
    start_run(2, 4, 0);
    ready = 1;
    run_until_idle(20, 0);

    // stop mid-run at bin 5
    start_run(0, 15, 0);
    guard = 0;
    while (m_bin != 5 && guard < 20) begin step(); guard++; end
    stop = 1;
    step();
    stop = 0;
    check("stop_bin", bin_o, 5);
    check("stop_valid", valid_o, 0);
    step();

    // asynchronous reset between edges at bin 7
    start_run(0, 15, 0);
    guard = 0;
    while (m_bin != 7 && guard < 20) begin step(); guard++; end
    #2 rst_n = 0;
    #1;
    model_reset();
    check_outputs();
    step();
    rst_n = 1;
    start_run(11, 13, 0);
    check("post_rst_bin", bin_o, 11);
    run_until_idle(20, 0);

    // single-value range
    start_run(10, 10, 0);
    check("single_gray", gray_o, 15);
    step();
    check("single_done", done_o, 1);
    step();

`ifdef GRAY_SEQ_LOOP_EN
    loop = 1;
    start_run(14, 15, 0);
    loop = 0;
    for (int i = 0; i < 8; i++) step();
    check("loop_running", valid_o, 1);
    stop = 1;
    step();
    stop = 0;
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 24) == 0);
      ready = $urandom_range(0, 3) != 0;
      dir   = $urandom_range(0, 1);
      lo    = W'($urandom_range(0, 15));
      hi    = W'($urandom_range(0, 15));
`ifdef GRAY_SEQ_LOOP_EN
      loop  = ($urandom_range(0, 3) == 0);
`endif
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_seq_ctrl.md
Name: gray_seq_ctrl

Overview:
- Sequencer that walks a programmable binary range and presents each value with its Gray encoding on a valid/ready stream.
- Instantiates the existing bin2gray converter on its internal binary register; gray_o is that converter's output.
- Sits between a control master (start/stop, range, direction) and downstream consumers of Gray codes, e.g. position encoders and pointer test generators.

Parameters:
- WIDTH, 4, bit width of range bounds, binary value and Gray code (must be >= 2).

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  start request; sampled only in IDLE.
- stop_i  input  1  abort request; sampled in RUN.
- dir_i  input  1  direction, sampled with start_i: 0 = up (lo to hi), 1 = down (hi to lo).
- lo_i  input  WIDTH  lower bound, inclusive; sampled with start_i.
- hi_i  input  WIDTH  upper bound, inclusive; sampled with start_i.
- ready_i  input  1  downstream accepts the current code.
- valid_o  output  1  bin_o/gray_o hold a valid code.
- bin_o  output  WIDTH  current binary value (registered).
- gray_o  output  WIDTH  bin2gray(bin_o); combinational from the bin_o register only.
- busy_o  output  1  high in RUN and DONE.
- done_o  output  1  one-cycle pulse after the last code is accepted.
- err_o  output  1  one-cycle pulse on rejected start (lo_i > hi_i).

Behaviour:
- Reset, asynchronous on rst_ni low:
  - State = IDLE.
  - valid_o = 0, bin_o = 0, gray_o = 0, busy_o = 0, done_o = 0, err_o = 0.
  - Latched lo/hi/dir registers = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 with lo_i <= hi_i: latch lo_i/hi_i/dir_i. Next cycle: RUN, valid_o=1, bin_o = dir_i ? hi_i : lo_i.
  - start_i=1 with lo_i > hi_i: err_o=1 for the next cycle only; stay IDLE; bin_o unchanged.
  - start_i=0: hold.
- RUN:
  - valid_o=1 throughout. bin_o and gray_o are stable while ready_i=0.
  - Handshake: transfer happens on a cycle with valid_o & ready_i.
  - Transfer, not last: bin_o +1 (up) or -1 (down) next cycle, valid_o stays 1. Throughput is 1 code per cycle while ready_i is held high.
  - Transfer of the last value (hi if up, lo if down): next cycle state DONE, valid_o=0, bin_o holds the last value.
  - stop_i=1 has priority over a same-cycle transfer: next cycle IDLE, valid_o=0, no done_o, bin_o holds.
- DONE: done_o=1 for exactly this cycle; unconditional transition to IDLE next cycle.
- Single-value range (lo == hi): exactly one transfer, then DONE.
- Full range (lo=0, hi=2^WIDTH-1): all 2^WIDTH codes emitted. No wrap-around in the counter; the last-value compare ends the sequence before overflow.
- Latency: start_i to first valid_o = 1 cycle. Last transfer to done_o = 1 cycle.
- start_i outside IDLE is ignored. stop_i outside RUN is ignored.
- Reset asserted mid-sequence returns all outputs to reset values immediately, without waiting for a clock edge.
- Invariant while valid_o is high: consecutive accepted gray_o values differ in exactly one bit.

Optional Feature:
- Macro: GRAY_SEQ_LOOP_EN.
- Defined:
  - Adds input port loop_i (1 bit), sampled with start_i.
  - If loop_i is latched high, transfer of the last value reloads the start value (lo if up, hi if down) next cycle and stays in RUN with valid_o=1.
  - No DONE state is entered and no done_o pulse occurs; only stop_i or reset ends the sequence.
  - If loop_i is latched low, behaviour is as without the macro.
- Not defined: no loop_i port; behaviour exactly as specified above.

Test Plan:
- Reset, then start_i with lo=0, hi=15, dir=0, ready_i=1: 16 consecutive transfers, gray_o = 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000; done_o pulses 1 cycle after gray 1000 is accepted.
- start_i with lo=3, hi=6, dir=1, ready_i toggling 1/0: bin_o sequence 6,5,4,3; each value held while ready_i=0; done_o pulses once; busy_o falls the cycle after done_o.
- start_i with lo=9, hi=2: err_o=1 for 1 cycle, valid_o stays 0, state stays IDLE; a following valid start runs normally.
- Mid-run stop_i with ready_i=1 at bin_o=5 (range 0..15, up): next cycle valid_o=0, bin_o=5, no done_o pulse.
- rst_ni driven low asynchronously (between clock edges) at bin_o=7: all outputs go to 0 before the next clock edge; a post-reset start begins from the new lo.
- lo=hi=10: exactly one transfer (gray 1111), then done_o. With GRAY_SEQ_LOOP_EN and loop_i=1, range 14..15 up: 14,15,14,15,... repeats until stop_i, with no done_o.
